// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
// PWM capture: measures period (rise to rise) and high time (rise to fall) of pwm_i in clk_i cycles.
// Optional glitch filter on the synchronized input: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int Resolution = 16,
  parameter int FilterLen  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  pwm_i,
  input  logic [Resolution-1:0] timeout_i,
  output logic [Resolution-1:0] period_o,
  output logic [Resolution-1:0] high_o,
  output logic                  valid_o,
  output logic                  change_o,
  output logic                  stuck_o,
  output logic                  level_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [Resolution-1:0] CNT_MAX = '1;
  localparam logic [Resolution-1:0] CNT_ONE = Resolution'(1);

  if (FilterLen < 2 || FilterLen > 15) begin : g_filterlen_check
    $error("pwm_capture: FilterLen must be in 2..15");
  end

  logic                  meta_p0, s_p1, lvl, lvl_d_p2;
  logic                  rise, fall;
  logic [1:0]            state;
  logic [Resolution-1:0] cnt, cnt_inc, hi_cap;
  logic                  first_meas, timeout_hit;

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_p0 <= 1'b0;
      s_p1    <= 1'b0;
    end else begin
      meta_p0 <= pwm_i;
      s_p1    <= meta_p0;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam logic [3:0] FLT_LAST = 4'(FilterLen - 1);
  logic [3:0] flt_cnt;
  logic       flt_lvl;

  // Level follows s_p1 only once it has disagreed for FilterLen consecutive cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flt_cnt <= 4'd0;
      flt_lvl <= 1'b0;
    end else if (s_p1 != flt_lvl) begin
      if (flt_cnt == FLT_LAST) begin
        flt_lvl <= s_p1;
        flt_cnt <= 4'd0;
      end else begin
        flt_cnt <= flt_cnt + 4'd1;
      end
    end else begin
      flt_cnt <= 4'd0;
    end
  end

  assign lvl = flt_lvl;
`else
  assign lvl = s_p1;
`endif

  // Stage p2: edge detector
  always_ff @(posedge clk_i) begin
    if (rst_i) lvl_d_p2 <= 1'b0;
    else       lvl_d_p2 <= lvl;
  end

  assign rise        = lvl & ~lvl_d_p2;
  assign fall        = ~lvl & lvl_d_p2;
  assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign timeout_hit = ((timeout_i != '0) && (cnt == timeout_i)) || (cnt == CNT_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_cap     <= '0;
      period_o   <= '0;
      high_o     <= '0;
      valid_o    <= 1'b0;
      change_o   <= 1'b0;
      stuck_o    <= 1'b0;
      level_o    <= 1'b0;
      first_meas <= 1'b0;
    end else begin
      valid_o  <= 1'b0;
      change_o <= 1'b0;
      if (!enable_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        level_o <= lvl;
        case (state)
          IDLE: begin
            if (rise) begin
              state      <= HIGH;
              cnt        <= CNT_ONE;
              stuck_o    <= 1'b0;
              first_meas <= 1'b1;
            end else begin
              cnt <= '0;
            end
          end
          HIGH, LOW: begin
            // An edge always beats a coincident timeout.
            if (rise && state == LOW) begin
              period_o   <= cnt;
              high_o     <= hi_cap;
              valid_o    <= 1'b1;
              change_o   <= first_meas || (cnt != period_o) || (hi_cap != high_o);
              first_meas <= 1'b0;
              cnt        <= CNT_ONE;
              state      <= HIGH;
            end else if (fall && state == HIGH) begin
              hi_cap <= cnt;
              cnt    <= cnt_inc;
              state  <= LOW;
            end else if (timeout_hit) begin
              stuck_o  <= 1'b1;
              period_o <= '0;
              high_o   <= '0;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
// Bench for pwm_capture: table-driven waveforms, random waveforms against a period/high model,
// and hand sequences for stuck, saturation, enable, reset and (filter build) glitch cases.
module tb_pwm_capture;
  localparam int RES = 16;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int MINW = 3;
`else
  localparam int MINW = 1;
`endif

  logic           clk = 1'b0, rst = 1'b0, en = 1'b0, pwm = 1'b0;
  logic [RES-1:0] tmo = '0;
  logic [RES-1:0] period_o, high_o;
  logic           valid_o, change_o, stuck_o, level_o;

  pwm_capture #(.Resolution(RES), .FilterLen(3)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .pwm_i(pwm), .timeout_i(tmo),
    .period_o(period_o), .high_o(high_o), .valid_o(valid_o), .change_o(change_o),
    .stuck_o(stuck_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit fresh; int h; int l; int reps; int exp_period; int exp_high; } vec_t;
  typedef struct { int p; int h; bit c; bit v; } rec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];
  int   checks = 0, passes = 0;
  bit   m_first;
  int   m_lp, m_lh;

  always @(negedge clk) begin
    rec_t r;
    if (valid_o || change_o) begin
      r.p = int'(period_o); r.h = int'(high_o); r.c = change_o; r.v = valid_o;
      obs_q.push_back(r);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Model: each completed period reports (high+low, high); change when first since arming or pair differs.
  task automatic push_expect(input int p, input int h);
    rec_t r;
    r.p = p; r.h = h; r.v = 1'b1;
    r.c = m_first || (p != m_lp) || (h != m_lh);
    m_first = 1'b0; m_lp = p; m_lh = h;
    exp_q.push_back(r);
  endtask

  task automatic wave(input int h, input int l);
    pwm = 1'b1; repeat (h) tick();
    pwm = 1'b0; repeat (l) tick();
  endtask

  task automatic end_group(input string nm);
    pwm = 1'b1;
    repeat (10) tick();
    chk($sformatf("%s_count", nm), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_period[%0d]", nm, i), obs_q[i].p, exp_q[i].p);
      chk($sformatf("%s_high[%0d]", nm, i), obs_q[i].h, exp_q[i].h);
      chk($sformatf("%s_change[%0d]", nm, i), obs_q[i].c, exp_q[i].c);
      chk($sformatf("%s_valid[%0d]", nm, i), obs_q[i].v, exp_q[i].v);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    pwm = 1'b0; rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    m_first = 1'b1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_period"}, period_o, 0);
    chk({nm, "_high"}, high_o, 0);
    chk({nm, "_valid"}, valid_o, 0);
    chk({nm, "_change"}, change_o, 0);
    chk({nm, "_stuck"}, stuck_o, 0);
    chk({nm, "_level"}, level_o, 0);
  endtask

  initial begin
    vec_t tbl[5];
    int   n, h, l, ph, pl;

    tbl[0] = '{1'b1, 25, 75, 4, 100, 25};
    tbl[1] = '{1'b1, 10, 90, 3, 100, 10};
    tbl[2] = '{1'b0, 40, 60, 3, 100, 40};
    tbl[3] = '{1'b1, MINW, MINW, 6, 2*MINW, MINW};
    tbl[4] = '{1'b1, 7, 13, 3, 20, 7};

    en = 1'b1;
    rst = 1'b1; pwm = 1'b1;
    repeat (3) tick();
    chk_zero("reset");
    do_reset();

    // Table: consecutive entries without fresh share one armed run.
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].fresh) begin
        if (i > 0) end_group($sformatf("tbl%0d", i - 1));
        do_reset();
      end
      for (int r = 0; r < tbl[i].reps; r++) begin
        wave(tbl[i].h, tbl[i].l);
        push_expect(tbl[i].exp_period, tbl[i].exp_high);
      end
    end
    end_group("tbl4");

    // Random waveforms, sometimes repeating the previous shape.
    do_reset();
    ph = 10; pl = 10;
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        h = ph; l = pl;
      end else begin
        h = int'($urandom_range(MINW, 40));
        l = int'($urandom_range(MINW, 40));
      end
      wave(h, l);
      push_expect(h + l, h);
      ph = h; pl = l;
    end
    end_group("rand");

    // Stuck high with timeout 500, then resume 10/10.
    do_reset();
    tmo = 16'd500;
    wave(10, 10); push_expect(20, 10);
    wave(10, 10); push_expect(20, 10);
    pwm = 1'b1;
    n = 0;
    while (!stuck_o && n < 600) begin tick(); n++; end
    chk("stuck_hi_latency_ok", (n >= 500 && n <= 506), 1);
    chk("stuck_hi_stuck", stuck_o, 1);
    chk("stuck_hi_level", level_o, 1);
    chk("stuck_hi_period", period_o, 0);
    chk("stuck_hi_high", high_o, 0);
    pwm = 1'b0; repeat (10) tick();
    chk("stuck_hold_before_rise", stuck_o, 1);
    chk("stuck_level_tracks", level_o, 0);
    m_first = 1'b1;
    pwm = 1'b1; repeat (5) tick();
    chk("stuck_cleared_by_rise", stuck_o, 0);
    repeat (5) tick();
    pwm = 1'b0; repeat (10) tick();
    push_expect(20, 10);
    end_group("stuck");
    tmo = '0;

    // Saturation with timeout 0: stuck low.
    do_reset();
    pwm = 1'b1; repeat (5) tick();
    pwm = 1'b0;
    n = 5;
    while (!stuck_o && n < 70000) begin tick(); n++; end
    chk("sat_latency_ok", (n >= 65535 && n <= 65545), 1);
    chk("sat_stuck", stuck_o, 1);
    chk("sat_level", level_o, 0);
    chk("sat_period", period_o, 0);
    chk("sat_count", obs_q.size(), 0);
    obs_q.delete();

    // Enable dropped mid-period, then re-armed.
    do_reset();
    wave(20, 30); push_expect(50, 20);
    pwm = 1'b1; repeat (20) tick();
    pwm = 1'b0; repeat (10) tick();
    en = 1'b0; repeat (5) tick();
    chk("en_hold_period", period_o, 50);
    chk("en_hold_high", high_o, 20);
    en = 1'b1; repeat (20) tick();
    m_first = 1'b1;
    wave(20, 30); push_expect(50, 20);
    end_group("enable");

    // Reset mid-period clears all outputs on the next edge.
    repeat (3) tick();
    rst = 1'b1; tick();
    chk_zero("midrst");
    rst = 1'b0;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    do_reset();
    wave(50, 20); pwm = 1'b1; repeat (2) tick(); pwm = 1'b0; repeat (28) tick();
    push_expect(100, 50);
    wave(50, 20); push_expect(70, 50);
    wave(3, 27);  push_expect(30, 3);
    end_group("filter");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
